// File: rtl/prbs_psk_modulator_pkg.sv
// Shared types and constants for the PRBS BPSK/QPSK test modulator.
package mod_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Second feedback tap (state index) for each supported polynomial.
   localparam int unsigned TAP_ORDER7  = 5;   // x^7  + x^6  + 1
   localparam int unsigned TAP_ORDER15 = 13;  // x^15 + x^14 + 1
   localparam int unsigned TAP_ORDER23 = 17;  // x^23 + x^18 + 1

   function automatic int unsigned prbs_tap(input int unsigned order);
      case (order)
         32'd15:  return TAP_ORDER15;
         32'd23:  return TAP_ORDER23;
         default: return TAP_ORDER7;
      endcase
   endfunction

   // Largest amplitude whose negation still fits in out_w signed bits.
   function automatic int unsigned amp_max(input int unsigned out_w);
      return (32'd1 << (out_w - 32'd1)) - 32'd1;
   endfunction

endpackage

// File: rtl/prbs_psk_modulator_lfsr.sv
// Fibonacci PRBS generator; o_bit is the feedback bit shifted in on the next advance.
module prbs_lfsr
   import mod_pkg::*;
#(
   parameter int unsigned ORDER = 7
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_seed,
   input  logic i_advance,
   output logic o_bit
);

   localparam int unsigned TAP = prbs_tap(ORDER);

   logic [ORDER-1:0] r_state;
   logic             w_fb;

   assign w_fb  = r_state[ORDER-1] ^ r_state[TAP];
   assign o_bit = w_fb;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= '1;
      end else if (i_seed) begin
         r_state <= '1;
      end else if (i_advance) begin
         r_state <= {r_state[ORDER-2:0], w_fb};
      end
   end

endmodule

// File: rtl/prbs_psk_modulator.sv
// PRBS-driven BPSK/QPSK burst modulator emitting a registered signed IF stream at fs/4.
module prbs_psk_modulator
   import mod_pkg::*;
#(
   parameter int unsigned OUT_W      = 12,
   parameter int unsigned PRBS_ORDER = 7,
   parameter int unsigned SPS        = 8,
   parameter int unsigned LEN_W      = 16
) (
   input  logic                    ip_clock,
   input  logic                    ip_reset,
   input  logic                    ip_enable,
   input  logic                    ip_mode,
   input  logic [OUT_W-2:0]        ip_amp,
   input  logic                    ip_start,
   input  logic [LEN_W-1:0]        ip_len,
   output logic signed [OUT_W-1:0] op_if,
   output logic                    op_valid,
   output logic                    op_busy,
   output logic                    op_done
);

   localparam int unsigned     CNT_W     = $clog2(SPS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);
   localparam logic [OUT_W-2:0] AMP_LIMIT = (OUT_W-1)'(amp_max(OUT_W));

   state_t                  r_state, w_state_nxt;
   logic                    r_mode;
   logic [OUT_W-2:0]        r_amp;
   logic [LEN_W-1:0]        r_len, r_sym;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_i_neg, r_q_neg;
   logic signed [OUT_W-1:0] r_if;
   logic                    r_valid, r_done, r_busy;

   logic                    w_seed, w_emit, w_adv, w_bit, w_sym_end;
   logic                    w_i_neg, w_q_neg, w_neg;
   logic signed [OUT_W-1:0] w_pos, w_sample;

   prbs_lfsr #(.ORDER(PRBS_ORDER)) u_lfsr (
      .i_clock   (ip_clock),
      .i_reset   (ip_reset),
      .i_seed    (w_seed),
      .i_advance (w_adv),
      .o_bit     (w_bit)
   );

   // Symbol bits are drawn from the LFSR on the sample that first needs them
   // (I at sample 0, Q at sample 1 in QPSK) instead of at start acceptance.
   always_comb begin
      w_sym_end = (r_cnt == CNT_LAST);
      w_i_neg   = (r_cnt == '0) ? w_bit : r_i_neg;
      w_q_neg   = r_mode ? ((r_cnt == CNT_W'(1)) ? w_bit : r_q_neg) : w_i_neg;
      w_neg     = 1'b0;
      unique case (r_cnt[1:0])
         2'd0:    w_neg = w_i_neg;
         2'd1:    w_neg = ~w_q_neg;
         2'd2:    w_neg = ~w_i_neg;
         default: w_neg = w_q_neg;
      endcase
      w_pos    = {1'b0, r_amp};
      w_sample = w_neg ? -w_pos : w_pos;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_seed      = 1'b0;
      w_emit      = 1'b0;
      w_adv       = 1'b0;
      if (ip_enable) begin
         unique case (r_state)
            ST_IDLE: begin
               if (ip_start) begin
                  w_seed      = 1'b1;
                  w_state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               w_emit = 1'b1;
               w_adv  = (r_cnt == '0) | (r_mode & (r_cnt == CNT_W'(1)));
               if (w_sym_end && (r_len != '0) && (r_sym == r_len - LEN_W'(1)))
                  w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge ip_clock or negedge ip_reset) begin
      if (!ip_reset) r_state <= ST_IDLE;
      else           r_state <= w_state_nxt;
   end

   always_ff @(posedge ip_clock or negedge ip_reset) begin
      if (!ip_reset) begin
         r_mode  <= 1'b0;
         r_amp   <= '0;
         r_len   <= '0;
         r_sym   <= '0;
         r_cnt   <= '0;
         r_i_neg <= 1'b0;
         r_q_neg <= 1'b0;
         r_if    <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         // Busy stays up through the done pulse and drops together with it.
         r_busy <= (w_state_nxt != ST_IDLE) | (ip_enable & (r_state == ST_DONE));
         if (ip_enable) begin
            r_valid <= w_emit;
            r_done  <= (r_state == ST_DONE);
            if (w_seed) begin
               r_mode <= ip_mode;
               r_amp  <= (ip_amp > AMP_LIMIT) ? AMP_LIMIT : ip_amp;
               r_len  <= ip_len;
               r_sym  <= '0;
               r_cnt  <= '0;
            end
            if (w_emit) begin
               r_if    <= w_sample;
               r_i_neg <= w_i_neg;
               r_q_neg <= w_q_neg;
               r_cnt   <= w_sym_end ? '0 : r_cnt + CNT_W'(1);
               if (w_sym_end) r_sym <= r_sym + LEN_W'(1);
            end else begin
               r_if <= '0;
            end
         end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
         end
      end
   end

   assign op_if    = r_if;
   assign op_valid = r_valid;
   assign op_busy  = r_busy;
   assign op_done  = r_done;

endmodule

// File: doc/prbs_psk_modulator.md
# prbs_psk_modulator

Parametrised PRBS-driven BPSK/QPSK test modulator producing a signed real IF stream at fs/4. It generates a reproducible PRBS bitstream, maps it to BPSK or QPSK symbols, and holds each symbol for SPS samples. Symbols are mixed onto an fs/4 carrier and emitted as registered two's-complement samples. It sits at the head of the transmit test chain and adds burst control, run-time mode selection and sample-valid signalling for downstream DAC/filter blocks.

## Interface
- OUT_W, 12: output sample width (bits), 4..16.
- PRBS_ORDER, 7: LFSR order; legal values 7 (x^7+x^6+1), 15 (x^15+x^14+1), 23 (x^23+x^18+1).
- SPS, 8: samples per symbol; multiple of 4, ≥4.
- LEN_W, 16: width of burst-length input.
- ip_clock  in  1  clock, rising edge only.
- ip_reset  in  1  reset, asynchronous, active-low.
- ip_enable  in  1  global clock-enable; low = stall.
- ip_mode  in  1  0 = BPSK, 1 = QPSK; sampled only on accepted start.
- ip_amp  in  OUT_W-1  unsigned symbol amplitude; sampled on accepted start.
- ip_start  in  1  burst request pulse.
- ip_len  in  LEN_W  symbols in burst; 0 = continuous until reset.
- op_if  out  OUT_W  signed IF sample.
- op_valid  out  1  op_if carries a burst sample this cycle.
- op_busy  out  1  high while state ≠ IDLE.
- op_done  out  1  one-cycle pulse after last sample of a finite burst.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs 0.
- IDLE: op_if = 0, op_valid = 0. ip_start=1 with ip_enable=1 is accepted: latch mode/amp/len, reseed LFSR to all-ones, clear counters, load first symbol, go RUN.
- LFSR: Fibonacci; fb = s[ORDER-1] ^ s[tap]; s <= {s[ORDER-2:0], fb}; output bit = fb. It advances only when a symbol is loaded: 1 bit (BPSK) or 2 bits (QPSK, first bit → I, second → Q).
- Mapping: bit 0 → +amp, bit 1 → −amp. In BPSK, Q = I.
- Carrier phase p cycles 0,1,2,3 per valid sample. Output: p0 = I, p1 = −Q, p2 = −I, p3 = Q.
- Width rule: amp ≤ 2^(OUT_W-1)−1, so negation never overflows. Results are sign-extended to OUT_W.
- Sample counter runs 0..SPS−1. At SPS−1, the next symbol loads and the symbol counter increments. Phase continues across symbols; SPS%4 = 0 keeps symbol boundaries at p0.
- RUN: after the last sample of symbol ip_len−1 (ip_len ≠ 0), go DONE. In DONE: op_done=1, op_valid=0, op_if=0 for one cycle, then IDLE.
- ip_len = 0: RUN never exits; the LFSR wraps naturally with period 2^ORDER−1.
- ip_enable low: all state, counters, LFSR and op_if hold; op_valid = 0, op_done held off. A DONE pulse is deferred until enable returns.
- ip_start during RUN/DONE: ignored.
- ip_reset mid-burst: immediate return to IDLE, outputs 0, burst lost.

## Timing
- Start accepted at edge k. First sample (p0, symbol 0) appears on op_if/op_valid after edge k+1. One sample per enabled cycle after that.
- A finite burst gives exactly ip_len·SPS valid samples on consecutive enabled cycles.
- op_done rises one cycle after the last valid sample. op_busy falls with op_done's falling edge.
- All outputs are registered; no combinational input→output path.

## Structure
- Package mod_pkg: state enum, PRBS tap constants per order, function returning the tap for PRBS_ORDER, OUT_W/amp range check constant.
- Sub-module prbs_lfsr (parameter ORDER; ports clock, reset, seed load, advance, bit out). The modulator instantiates it once and advances it twice per QPSK symbol.

## Test plan
- BPSK, ORDER=7, SPS=4, amp=1000, len=2, start at edge 0 → samples 1000,0... no: +1000,−1000,−1000,+1000 per symbol. With Q=I, symbol 0 gives 1000,−1000,−1000,1000, and symbol 1 repeats it (first 6 PRBS bits are 0). op_done at 9th cycle.
- QPSK, ORDER=7, SPS=4, amp=500, len=4 → symbols 0–2 all +500/+500. Symbol 3 uses bits 7,8 (1,0): I = −500, Q = +500, so samples −500,−500,+500,+500.
- Continuous BPSK, ORDER=7, SPS=4 → symbol sequence repeats every 127 symbols (508 samples). op_done never asserts.
- Enable dropped for 3 cycles mid-symbol → op_if frozen, op_valid low, and sample order resumes exactly. Total valid count remains len·SPS.
- Reset asserted mid-burst, then a new start → outputs 0 during reset, and the new burst reproduces the first-burst sequence bit-exactly.
- Start pulsed during RUN → ignored, sample stream unchanged. amp = 2^(OUT_W-1)−1 → full-scale ±2047 with no wrap.
